riscv_fetch_queue: RTL

Instruction-fetch front end for the RISC-V pipeline core. It owns the fetch PC, issues word reads to the 256-entry instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to the IF/ID register through a valid/ready handshake. On a branch or jump redirect from the execute stage, it flushes all buffered and in-flight fetches.

---
 rtl/riscv_fetch_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to
// instruction memory and buffers returned {instr, pc} pairs in a small FIFO.
module riscv_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  output logic                    o_imem_req,
  output logic [ADDR_W-1:0]       o_imem_addr,
  input  logic [31:0]             i_imem_rdata,
  input  logic                    i_redirect,
  input  logic [PC_W-1:0]         i_redirect_pc,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [31:0]             o_out_instr,
  output logic [PC_W-1:0]         o_out_pc,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_req_pc;
  logic             r_inflight;
  logic             r_squash;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [PC_W-1:0]  r_pc_mem    [DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic [CRD_W-1:0] w_credit;
  logic             w_req;

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & i_out_ready;
  assign w_push   = r_inflight & ~r_squash;
  // Occupancy seen by a new request: buffered + in flight, minus this cycle's pop.
  assign w_credit = CRD_W'(r_count) + CRD_W'(r_inflight) - CRD_W'(w_pop);
  assign w_req    = ~i_reset & ~i_redirect & (w_credit < CRD_W'(DEPTH));

  // Fetch PC, request tracking and FIFO pointers; redirect has priority.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_squash   <= r_inflight;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
        r_req_pc   <= r_fetch_pc;
      end
      r_inflight <= w_req;
      r_squash   <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_redirect) begin
      r_instr_mem[r_wptr] <= i_imem_rdata;
      r_pc_mem[r_wptr]    <= r_req_pc;
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc[ADDR_W-1:0];
  assign o_out_valid = w_valid;
  assign o_out_instr = w_valid ? r_instr_mem[r_rptr] : 32'h0;
  assign o_out_pc    = w_valid ? r_pc_mem[r_rptr] : '0;
  assign o_count     = r_count;

endmodule
